// File: rtl/ldpc_loop_pkg.sv
// ldpc_loop_pkg: shared FSM state type and status-word bit positions for the loop framer.
package ldpc_loop_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, STAT} state_t;
   function automatic int err_short_bit(input int lw);
      return lw;
   endfunction
   function automatic int err_long_bit(input int lw);
      return lw + 1;
   endfunction
endpackage

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: first-word fall-through synchronous FIFO; writes when full and reads when empty are ignored.
module axis_sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr_valid,
   input  logic [WIDTH-1:0] i_wr_data,
   output logic             o_full,
   input  logic             i_rd_ready,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wp, r_rp;
   logic             w_wr, w_rd;
   // extra pointer bit distinguishes full from empty
   assign o_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign o_empty   = r_wp == r_rp;
   assign w_wr      = i_wr_valid && !o_full;
   assign w_rd      = i_rd_ready && !o_empty;
   assign o_rd_data = r_mem[r_rp[AW-1:0]];
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_wr) r_wp <= r_wp + 1'b1;
         if (w_rd) r_rp <= r_rp + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wp[AW-1:0]] <= i_wr_data;
   end
endmodule

// File: rtl/ldpc_loop_framer.sv
// ldpc_loop_framer: enforces control-word frame lengths on a data stream, buffers beats in a FIFO
// with regenerated TLAST, and emits one status word per frame.
module ldpc_loop_framer
   import ldpc_loop_pkg::*;
#(
   parameter int DATA_DEPTH = 16,
   parameter int LEN_WIDTH  = 16,
   parameter int CTRL_WIDTH = 32,
   parameter int STAT_WIDTH = 32,
   parameter int DIN_WIDTH  = 32,
   parameter int DOUT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CTRL_WIDTH-1:0] i_ctrl_tdata,
   input  logic                  i_ctrl_tvalid,
   output logic                  o_ctrl_tready,
   input  logic [DIN_WIDTH-1:0]  i_din_tdata,
   input  logic                  i_din_tlast,
   input  logic                  i_din_tvalid,
   output logic                  o_din_tready,
   output logic [STAT_WIDTH-1:0] o_stat_tdata,
   output logic                  o_stat_tvalid,
   input  logic                  i_stat_tready,
   output logic [DOUT_WIDTH-1:0] o_dout_tdata,
   output logic                  o_dout_tlast,
   output logic                  o_dout_tvalid,
   input  logic                  i_dout_tready
);
   localparam int ES = err_short_bit(LEN_WIDTH);
   localparam int EL = err_long_bit(LEN_WIDTH);

   if (CTRL_WIDTH != STAT_WIDTH) begin : g_err_ctrl
      $error("ctrl and status DATA_WIDTH differ");
   end
   if (DIN_WIDTH != DOUT_WIDTH) begin : g_err_data
      $error("din and dout DATA_WIDTH differ");
   end
   if (CTRL_WIDTH < LEN_WIDTH + 2) begin : g_err_len
      $error("ctrl DATA_WIDTH too small for length and flags");
   end

   state_t                r_state;
   logic                  r_ctrl_rdy, r_stat_vld, r_short, r_long;
   logic [CTRL_WIDTH-1:0] r_ctrl;
   logic [LEN_WIDTH-1:0]  r_cnt, w_len, w_cnt_nxt;
   logic [STAT_WIDTH-1:0] w_stat;
   logic [DIN_WIDTH:0]    w_rd_data;
   logic                  w_full, w_empty, w_ctrl_hs, w_din_hs, w_wr, w_last;

   assign w_len         = r_ctrl[LEN_WIDTH-1:0];
   assign w_cnt_nxt     = r_cnt + 1'b1;
   assign w_last        = (w_cnt_nxt == w_len) || i_din_tlast;
   assign o_ctrl_tready = r_ctrl_rdy;
   assign o_din_tready  = (r_state == RUN) ? !w_full : (r_state == DRAIN);
   assign w_ctrl_hs     = r_ctrl_rdy && i_ctrl_tvalid;
   assign w_din_hs      = o_din_tready && i_din_tvalid;
   assign w_wr          = w_din_hs && (r_state == RUN);
   assign o_stat_tvalid = r_stat_vld;
   assign o_stat_tdata  = w_stat;
   assign o_dout_tvalid = !w_empty;
   assign o_dout_tlast  = w_rd_data[DIN_WIDTH];
   assign o_dout_tdata  = DOUT_WIDTH'(w_rd_data[DIN_WIDTH-1:0]);

   // upper ctrl bits pass through; length field and flag bits are replaced
   always_comb begin
      w_stat                = STAT_WIDTH'(r_ctrl);
      w_stat[LEN_WIDTH-1:0] = r_cnt;
      w_stat[ES]            = r_short;
      w_stat[EL]            = r_long;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_ctrl_rdy <= 1'b0;
         r_stat_vld <= 1'b0;
         r_short    <= 1'b0;
         r_long     <= 1'b0;
         r_cnt      <= '0;
         r_ctrl     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_ctrl_rdy <= 1'b1;
               if (w_ctrl_hs) begin
                  r_ctrl     <= i_ctrl_tdata;
                  r_cnt      <= '0;
                  r_short    <= 1'b0;
                  r_long     <= 1'b0;
                  r_ctrl_rdy <= 1'b0;
                  r_stat_vld <= i_ctrl_tdata[LEN_WIDTH-1:0] == '0;
                  r_state    <= (i_ctrl_tdata[LEN_WIDTH-1:0] == '0) ? STAT : RUN;
               end
            end
            RUN: begin
               if (w_din_hs) begin
                  r_cnt <= w_cnt_nxt;
                  if (w_cnt_nxt == w_len) begin
                     r_state    <= i_din_tlast ? STAT : DRAIN;
                     r_stat_vld <= i_din_tlast;
                     r_long     <= !i_din_tlast;
                  end else if (i_din_tlast) begin
                     r_state    <= STAT;
                     r_stat_vld <= 1'b1;
                     r_short    <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (w_din_hs && i_din_tlast) begin
                  r_state    <= STAT;
                  r_stat_vld <= 1'b1;
               end
            end
            default: begin
               if (i_stat_tready) begin
                  r_state    <= IDLE;
                  r_stat_vld <= 1'b0;
                  r_ctrl_rdy <= 1'b1;
               end
            end
         endcase
      end
   end

   axis_sync_fifo #(.WIDTH(DIN_WIDTH + 1), .DEPTH(DATA_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_wr_valid (w_wr),
      .i_wr_data  ({w_last, i_din_tdata}),
      .o_full     (w_full),
      .i_rd_ready (i_dout_tready),
      .o_rd_data  (w_rd_data),
      .o_empty    (w_empty)
   );
endmodule

// File: tb/tb_ldpc_loop_framer.sv
// tb_ldpc_loop_framer: directed frames with hand-computed expectations; scoreboard queues checked by a
// negedge monitor on the dout and status streams.
module tb_ldpc_loop_framer;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_ctrl_tdata;
   logic        i_ctrl_tvalid;
   logic        o_ctrl_tready;
   logic [31:0] i_din_tdata;
   logic        i_din_tlast;
   logic        i_din_tvalid;
   logic        o_din_tready;
   logic [31:0] o_stat_tdata;
   logic        o_stat_tvalid;
   logic        i_stat_tready;
   logic [31:0] o_dout_tdata;
   logic        o_dout_tlast;
   logic        o_dout_tvalid;
   logic        i_dout_tready;

   int          checks = 0;
   int          errors = 0;
   logic [32:0] dq [$];
   logic [31:0] sq [$];

   always #5 clk = ~clk;

   ldpc_loop_framer #(.DATA_DEPTH(16), .LEN_WIDTH(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_ctrl_tdata  (i_ctrl_tdata),
      .i_ctrl_tvalid (i_ctrl_tvalid),
      .o_ctrl_tready (o_ctrl_tready),
      .i_din_tdata   (i_din_tdata),
      .i_din_tlast   (i_din_tlast),
      .i_din_tvalid  (i_din_tvalid),
      .o_din_tready  (o_din_tready),
      .o_stat_tdata  (o_stat_tdata),
      .o_stat_tvalid (o_stat_tvalid),
      .i_stat_tready (i_stat_tready),
      .o_dout_tdata  (o_dout_tdata),
      .o_dout_tlast  (o_dout_tlast),
      .o_dout_tvalid (o_dout_tvalid),
      .i_dout_tready (i_dout_tready)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (o_dout_tvalid && i_dout_tready) begin
         if (dq.size() == 0) chk("dout_unexpected", {31'd0, o_dout_tlast, o_dout_tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
         else chk("dout", {31'd0, o_dout_tlast, o_dout_tdata}, {31'd0, dq.pop_front()});
      end
      if (o_stat_tvalid && i_stat_tready) begin
         if (sq.size() == 0) chk("stat_unexpected", {32'd0, o_stat_tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
         else chk("status", {32'd0, o_stat_tdata}, {32'd0, sq.pop_front()});
      end
   end

   task automatic send_ctrl(input logic [31:0] w);
      int n = 0;
      logic hs = 1'b0;
      i_ctrl_tdata  = w;
      i_ctrl_tvalid = 1'b1;
      while (!hs && n < 200) begin
         @(negedge clk);
         hs = o_ctrl_tready;
         @(posedge clk);
         n++;
      end
      #1 i_ctrl_tvalid = 1'b0;
      if (!hs) chk("ctrl_timeout", {63'd0, hs}, 64'd1);
   endtask

   task automatic send_beat(input logic [31:0] d, input logic l);
      int n = 0;
      logic hs = 1'b0;
      i_din_tdata  = d;
      i_din_tlast  = l;
      i_din_tvalid = 1'b1;
      while (!hs && n < 200) begin
         @(negedge clk);
         hs = o_din_tready;
         @(posedge clk);
         n++;
      end
      #1 i_din_tvalid = 1'b0;
      if (!hs) chk("din_timeout", {63'd0, hs}, 64'd1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((dq.size() != 0 || sq.size() != 0) && n < 500) begin
         @(posedge clk);
         n++;
      end
      chk("drain", {32'd0, 16'(dq.size()), 16'(sq.size())}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      i_ctrl_tdata = '0; i_ctrl_tvalid = 1'b0;
      i_din_tdata = '0; i_din_tlast = 1'b0; i_din_tvalid = 1'b0;
      i_stat_tready = 1'b1; i_dout_tready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {60'd0, o_ctrl_tready, o_din_tready, o_stat_tvalid, o_dout_tvalid}, 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // normal frame
      dq.push_back({1'b0, 32'hA}); dq.push_back({1'b0, 32'hB});
      dq.push_back({1'b0, 32'hC}); dq.push_back({1'b1, 32'hD});
      sq.push_back(32'hAB00_0004);
      send_ctrl(32'hAB00_0004);
      send_beat(32'hA, 0); send_beat(32'hB, 0); send_beat(32'hC, 0); send_beat(32'hD, 1);
      wait_drain();

      // short frame
      dq.push_back({1'b0, 32'h11}); dq.push_back({1'b1, 32'h22});
      sq.push_back(32'h1201_0002);
      send_ctrl(32'h1200_0004);
      send_beat(32'h11, 0); send_beat(32'h22, 1);
      wait_drain();

      // long frame: beats 4-5 dropped
      dq.push_back({1'b0, 32'h31}); dq.push_back({1'b0, 32'h32}); dq.push_back({1'b1, 32'h33});
      sq.push_back(32'h3402_0003);
      send_ctrl(32'h3400_0003);
      for (int i = 1; i <= 5; i++) send_beat(32'h30 + i, i == 5);
      wait_drain();

      // zero-length frame
      i_stat_tready = 1'b0;
      sq.push_back(32'h5600_0000);
      send_ctrl(32'h5600_0000);
      @(negedge clk);
      chk("l0_stat_valid", {61'd0, o_stat_tvalid, o_din_tready, o_ctrl_tready}, 64'd4);
      @(posedge clk);
      #1 i_stat_tready = 1'b1;
      @(negedge clk);
      chk("l0_ctrl_blocked", {62'd0, o_din_tready, o_ctrl_tready}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("l0_ctrl_ready", {62'd0, o_stat_tvalid, o_ctrl_tready}, 64'd1);
      @(posedge clk);
      #1;
      wait_drain();

      // backpressure: FIFO fills at 16
      i_dout_tready = 1'b0;
      for (int i = 1; i <= 20; i++) dq.push_back({i == 20, 32'h100 + i});
      sq.push_back(32'h7800_0014);
      send_ctrl(32'h7800_0014);
      for (int i = 1; i <= 16; i++) send_beat(32'h100 + i, 0);
      i_din_tdata = 32'h111; i_din_tlast = 1'b0; i_din_tvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("full_backpressure", {62'd0, o_din_tready, o_dout_tvalid}, 64'd1);
      end
      @(posedge clk);
      #1 i_dout_tready = 1'b1;
      for (int i = 17; i <= 20; i++) send_beat(32'h100 + i, i == 20);
      wait_drain();

      // reset mid-frame, then a clean L=2 frame
      i_dout_tready = 1'b0;
      send_ctrl(32'h0000_0008);
      for (int i = 1; i <= 4; i++) send_beat(32'h200 + i, 0);
      i_din_tdata = 32'h205; i_din_tlast = 1'b0; i_din_tvalid = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0; i_din_tvalid = 1'b0;
      @(negedge clk);
      chk("mid_reset", {60'd0, o_ctrl_tready, o_din_tready, o_stat_tvalid, o_dout_tvalid}, 64'd0);
      @(posedge clk);
      #1 i_dout_tready = 1'b1;
      dq.push_back({1'b0, 32'h301}); dq.push_back({1'b1, 32'h302});
      sq.push_back(32'h9A00_0002);
      send_ctrl(32'h9A00_0002);
      send_beat(32'h301, 0); send_beat(32'h302, 1);
      wait_drain();
      repeat (10) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ldpc_loop_framer.md
Name: ldpc_loop_framer

Overview:
- Parametrised successor to the LDPC loopback wrapper: passes a control stream to a status stream and a data stream to a data output.
- Adds frame-length enforcement and buffering. Each control word gives the expected frame length in beats.
- Data beats pass through a FIFO. Output TLAST is regenerated from a beat counter.
- After each frame a status word reports the actual beat count and short/long-frame errors. Used as the loop stage around the LDPC core and as a bench loopback.

Parameters:
- DATA_DEPTH, 16, data FIFO depth in beats; power of two, ≥2.
- LEN_WIDTH, 16, width of the frame-length field in control and status words.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- s_axis_ctrl  AxisIf.slave  s_axis_ctrl.DATA_WIDTH  control words; bits [LEN_WIDTH-1:0] = frame length L.
- s_axis_din  AxisIf.slave  s_axis_din.DATA_WIDTH  input data beats with TLAST.
- m_axis_status  AxisIf.master  m_axis_status.DATA_WIDTH  one status word per control word.
- m_axis_dout  AxisIf.master  m_axis_dout.DATA_WIDTH  output data beats with regenerated TLAST.

Behaviour:
- Elaboration $error if any of these hold:
  - ctrl DATA_WIDTH != status DATA_WIDTH
  - din DATA_WIDTH != dout DATA_WIDTH
  - ctrl DATA_WIDTH < LEN_WIDTH+2
- Reset values: state=IDLE, FIFO empty, all tvalid=0, s_axis_ctrl.tready=0, s_axis_din.tready=0, beat counter=0, flags=0.
- Reset mid-frame flushes the FIFO and discards the frame. No status word is emitted for it.
- FSM states: IDLE, RUN, DRAIN, STAT.
- IDLE:
  - ctrl.tready=1, din.tready=0.
  - On ctrl handshake, latch the word and clear the counter.
  - If L=0, go to STAT with count 0, no flags, and no din consumed. Otherwise go to RUN.
- RUN:
  - din.tready = !fifo_full.
  - Each din handshake writes {tlast_out, tdata} to the FIFO and increments the counter.
  - tlast_out = (counter+1==L) || din.tlast.
  - Beat L carrying din.tlast: normal end, go to STAT.
  - din.tlast before beat L: go to STAT, set err_short.
  - Beat L without din.tlast: go to DRAIN, set err_long.
- DRAIN:
  - din.tready=1; beats are discarded and not written to the FIFO.
  - On a din beat with tlast, go to STAT.
- STAT:
  - status.tvalid=1, registered.
  - tdata layout: [LEN_WIDTH-1:0]=beats written to the FIFO, [LEN_WIDTH]=err_short, [LEN_WIDTH+1]=err_long, upper bits = latched ctrl upper bits.
  - Hold until tready, then go to IDLE.
  - ctrl is not accepted in the same cycle as the status handshake.
- Latency:
  - ctrl handshake at cycle t gives din.tready eligible at t+1.
  - Final accepted beat at t gives status.tvalid at t+1.
- Status ordering: status is independent of FIFO drain. It may be presented before all dout beats leave the FIFO.
- Data FIFO:
  - First-word fall-through; dout.tvalid = !fifo_empty.
  - Simultaneous read and write when full or empty is legal and keeps the count consistent.
  - Data order is preserved and no beat is lost under any tready pattern.
- Counter: LEN_WIDTH bits and never wraps, since L ≤ 2^LEN_WIDTH-1 and RUN exits at L.
- AXIS rules: once tvalid is asserted, tdata/tlast stay stable until handshake.

Decomposition:
- ldpc_loop_pkg holds:
  - state enum typedef
  - status bit-position constants (ERR_SHORT_BIT=LEN_WIDTH, ERR_LONG_BIT=LEN_WIDTH+1), as functions of LEN_WIDTH
- One sub-module: axis_sync_fifo.
  - Parameters: WIDTH, DEPTH.
  - Ports: clk, rst, write/read handshakes, full, empty.
  - Used for the data path with WIDTH=DATA_WIDTH+1.

Test Plan:
- ctrl L=4; din 4 beats A..D, tlast on D → dout A..D with tlast on D only; status count=4, flags=00.
- ctrl L=4; din 2 beats, tlast on beat 2 → dout 2 beats with tlast on 2; status count=2, err_short=1.
- ctrl L=3; din 5 beats, tlast on 5 → dout 3 beats with tlast on 3; beats 4-5 consumed but dropped; status count=3, err_long=1.
- ctrl L=0 → no din accepted (din.tready stays 0); status count=0, flags=00 presented one cycle after the ctrl handshake; next ctrl accepted after the status handshake.
- DATA_DEPTH=16, L=20, dout.tready=0 → din.tready falls after 16 accepted beats; releasing dout.tready drains all 20 beats in order with tlast on 20.
- Assert rst during beat 5 of an L=8 frame → next cycle all tvalid=0, FIFO empty, no status; a following L=2 frame completes normally.
